slot_request_controller: RTL and testbench
==========================================

// Module: slot_request_controller
// PURPOSE
//  Upstream stage of calculate_new_capacity. Arbitrates car entry/exit requests against the
//  live occupancy vector (1 = slot occupied) and picks the slot (lowest free index on entry).
//  Emits the one-hot park_location toggle mask with a loc_valid strobe, then drives a timed
//  gate-open window. Also reports free-slot count and full status to the display/entry logic.
// PARAMETERS
//  N_SLOTS      8  number of slots = width of occupancy vector and park_location (2..8)
//  GATE_CYCLES  4  cycles gate_open stays high after a granted entry/exit (>=1)
// PORTS
//  clk             in   1  single system clock, rising edge
//  rst_n           in   1  synchronous, active-low reset
//  enter_req       in   1  level; car at entry gate, held until enter_ack/enter_nack
//  exit_req        in   1  level; car leaving slot exit_slot, held until exit_ack/exit_nack
//  exit_slot       in   3  slot index being vacated, sampled with exit_req
//  capacity_in     in   N_SLOTS  current occupancy register (parking_capacity)
//  park_location   out  N_SLOTS  one-hot toggle mask, nonzero only while loc_valid=1
//  loc_valid       out  1  1-cycle strobe; downstream register loads new_capacity this cycle
//  grant_slot      out  3  slot index of last granted operation, held until next grant
//  enter_ack       out  1  1-cycle pulse, entry granted
//  enter_nack      out  1  1-cycle pulse, entry refused (lot full)
//  exit_ack        out  1  1-cycle pulse, exit granted
//  exit_nack       out  1  1-cycle pulse, exit refused (slot empty or index >= N_SLOTS)
//  gate_open       out  1  barrier drive
//  free_count      out  4  number of zero bits in capacity_in, registered (1-cycle lag)
//  full            out  1  registered, 1 when free_count == 0
// BEHAVIOUR
//  - All outputs registered. Reset (rst_n=0 at a rising edge): state IDLE, every output 0.
//    Reset mid-operation aborts the operation: no strobe, gate closes next edge.
//  - FSM: IDLE -> UPDATE -> SETTLE -> GATE(xGATE_CYCLES) -> IDLE; IDLE -> REJECT -> IDLE.
//  - IDLE: requests are sampled only here. If exit_req and enter_req are both high, exit wins
//    (it frees space); enter_req stays pending and is served on a later return to IDLE.
//    exit_req: valid when exit_slot<N_SLOTS and capacity_in[exit_slot]=1 -> UPDATE,
//    else -> REJECT with exit_nack. enter_req: when some capacity_in bit is 0, choose the
//    lowest such index -> UPDATE, else -> REJECT with enter_nack.
//  - UPDATE (1 cycle): park_location = 1<<slot, loc_valid=1, grant_slot=slot, and the
//    matching ack=1, all in the same cycle. Exactly one bit set.
//  - SETTLE (1 cycle): park_location=0. The occupancy register updates at the end of
//    UPDATE. SETTLE guarantees capacity_in is current before the next IDLE decision, so no
//    slot is double-allocated.
//  - GATE: gate_open=1 for exactly GATE_CYCLES cycles, then IDLE. Requests are not sampled.
//  - REJECT (1 cycle): the nack pulse is asserted here. The requester must drop its request
//    on ack/nack. A request still high in the next IDLE cycle is treated as a new request.
//  - Latency: request seen in IDLE at cycle 0 -> loc_valid/ack at cycle 1, gate_open at
//    cycles 3..2+GATE_CYCLES, IDLE again at cycle 3+GATE_CYCLES.
//  - Request-to-request turnaround is 3+GATE_CYCLES cycles. A nack turns around in 2 cycles.
//  - free_count/full update every cycle from capacity_in, independent of FSM state.
//  - Bits of capacity_in at or above N_SLOTS are ignored. exit_slot is ignored without
//    exit_req.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles, capacity_in=8'h00 -> all outputs 0. One cycle after
//    release, free_count=8 and full=0.
//  2 Entry: capacity_in=8'b0000_0111, enter_req -> next cycle park_location=8'b0000_1000,
//    loc_valid=1, grant_slot=3, enter_ack=1. Gate high 4 cycles, IDLE 7 cycles after request.
//  3 Full: capacity_in=8'hFF, enter_req -> enter_nack pulse at cycle 1, loc_valid stays 0,
//    gate_open stays 0, full=1, free_count=0.
//  4 Exit: capacity_in=8'b0010_0000, exit_req with exit_slot=5 -> park_location=8'h20,
//    exit_ack. Then exit_slot=2 (empty) -> exit_nack, no strobe.
//  5 Simultaneous: enter_req=exit_req=1, exit_slot=0, capacity_in=8'h01 -> exit served first.
//    Entry is served after GATE, gets slot 0 (capacity_in now 8'h00).
//  6 Back-to-back entries with the bench modelling the capacity register: 8 grants on
//    slots 0..7, in order, with no duplicate. The 9th gets enter_nack. rst_n=0 during
//    GATE -> gate_open=0 on the next edge.

Source files
------------

// File: rtl/slot_request_controller.sv
// Parking-lot slot arbiter: serves entry/exit requests against the live occupancy vector,
// strobes a one-hot toggle mask for the capacity register and then holds the gate open.
module slot_request_controller #(
    parameter int unsigned N_SLOTS     = 8,
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enter_req_i,
    input  logic               exit_req_i,
    input  logic [2:0]         exit_slot_i,
    input  logic [N_SLOTS-1:0] capacity_i,
    output logic [N_SLOTS-1:0] park_location_o,
    output logic               loc_valid_o,
    output logic [2:0]         grant_slot_o,
    output logic               enter_ack_o,
    output logic               enter_nack_o,
    output logic               exit_ack_o,
    output logic               exit_nack_o,
    output logic               gate_open_o,
    output logic [3:0]         free_count_o,
    output logic               full_o
);

    localparam int unsigned GateCntW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GateCntW-1:0] GateLast = GateCntW'(GATE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StUpdate,
        StSettle,
        StGate,
        StReject
    } state_e;

    state_e               state_q, state_d;
    logic [GateCntW-1:0]  gate_cnt_q, gate_cnt_d;
    logic [N_SLOTS-1:0]   park_q, park_d;
    logic                 loc_valid_q, loc_valid_d;
    logic [2:0]           grant_q, grant_d;
    logic                 enter_ack_q, enter_ack_d;
    logic                 enter_nack_q, enter_nack_d;
    logic                 exit_ack_q, exit_ack_d;
    logic                 exit_nack_q, exit_nack_d;
    logic                 gate_open_q, gate_open_d;
    logic [3:0]           free_count_q, free_count_d;
    logic                 full_q, full_d;

    logic                 free_found;
    logic [2:0]           free_idx;
    logic [7:0]           cap_pad;
    logic                 exit_in_range;
    logic                 exit_valid;

    // Lowest free slot and free-slot count; only the N_SLOTS real bits take part.
    always_comb begin
        free_found   = 1'b0;
        free_idx     = '0;
        free_count_d = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (!capacity_i[i]) begin
                free_count_d = free_count_d + 4'd1;
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = 3'(i);
                end
            end
        end
        full_d = (free_count_d == 4'd0);
    end

    // Pad to 8 bits so any 3-bit exit_slot index is in range of the vector.
    always_comb begin
        cap_pad       = 8'(capacity_i);
        exit_in_range = ({29'd0, exit_slot_i} < N_SLOTS);
        exit_valid    = exit_in_range && cap_pad[exit_slot_i];
    end

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        grant_d      = grant_q;
        park_d       = '0;
        loc_valid_d  = 1'b0;
        enter_ack_d  = 1'b0;
        enter_nack_d = 1'b0;
        exit_ack_d   = 1'b0;
        exit_nack_d  = 1'b0;
        gate_open_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Exit has priority: it frees space, and a held entry is seen again later.
                if (exit_req_i) begin
                    if (exit_valid) begin
                        state_d     = StUpdate;
                        park_d      = N_SLOTS'(1) << exit_slot_i;
                        loc_valid_d = 1'b1;
                        grant_d     = exit_slot_i;
                        exit_ack_d  = 1'b1;
                    end else begin
                        state_d     = StReject;
                        exit_nack_d = 1'b1;
                    end
                end else if (enter_req_i) begin
                    if (free_found) begin
                        state_d     = StUpdate;
                        park_d      = N_SLOTS'(1) << free_idx;
                        loc_valid_d = 1'b1;
                        grant_d     = free_idx;
                        enter_ack_d = 1'b1;
                    end else begin
                        state_d      = StReject;
                        enter_nack_d = 1'b1;
                    end
                end
            end
            StUpdate: begin
                state_d = StSettle;
            end
            StSettle: begin
                state_d     = StGate;
                gate_cnt_d  = '0;
                gate_open_d = 1'b1;
            end
            StGate: begin
                if (gate_cnt_q == GateLast) begin
                    state_d = StIdle;
                end else begin
                    gate_cnt_d  = gate_cnt_q + GateCntW'(1);
                    gate_open_d = 1'b1;
                end
            end
            StReject: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            gate_cnt_q   <= '0;
            park_q       <= '0;
            loc_valid_q  <= 1'b0;
            grant_q      <= '0;
            enter_ack_q  <= 1'b0;
            enter_nack_q <= 1'b0;
            exit_ack_q   <= 1'b0;
            exit_nack_q  <= 1'b0;
            gate_open_q  <= 1'b0;
            free_count_q <= '0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            park_q       <= park_d;
            loc_valid_q  <= loc_valid_d;
            grant_q      <= grant_d;
            enter_ack_q  <= enter_ack_d;
            enter_nack_q <= enter_nack_d;
            exit_ack_q   <= exit_ack_d;
            exit_nack_q  <= exit_nack_d;
            gate_open_q  <= gate_open_d;
            free_count_q <= free_count_d;
            full_q       <= full_d;
        end
    end

    assign park_location_o = park_q;
    assign loc_valid_o     = loc_valid_q;
    assign grant_slot_o    = grant_q;
    assign enter_ack_o     = enter_ack_q;
    assign enter_nack_o    = enter_nack_q;
    assign exit_ack_o      = exit_ack_q;
    assign exit_nack_o     = exit_nack_q;
    assign gate_open_o     = gate_open_q;
    assign free_count_o    = free_count_q;
    assign full_o          = full_q;

    a_park_onehot: assert property (@(posedge clk_i) loc_valid_o |-> $onehot(park_location_o));
    a_park_idle:   assert property (@(posedge clk_i) !loc_valid_o |-> (park_location_o == '0));
    a_resp_excl:   assert property (@(posedge clk_i)
        $onehot0({enter_ack_o, enter_nack_o, exit_ack_o, exit_nack_o}));

endmodule

// File: tb/tb_slot_request_controller.sv
// Randomized self-checking bench for slot_request_controller; the bench plays the
// occupancy register and predicts every response from a transaction-level model.
module tb_slot_request_controller;

    localparam int N = 8;
    localparam int G = 4;

    logic       clk;
    logic       rst_n;
    logic       enter_req;
    logic       exit_req;
    logic [2:0] exit_slot;
    logic [7:0] capacity;
    logic [7:0] park_location;
    logic       loc_valid;
    logic [2:0] grant_slot;
    logic       enter_ack;
    logic       enter_nack;
    logic       exit_ack;
    logic       exit_nack;
    logic       gate_open;
    logic [3:0] free_count;
    logic       full;

    int         n_checks;
    int         n_errors;
    logic [7:0] model_cap;
    logic [2:0] last_grant;

    slot_request_controller #(
        .N_SLOTS     (N),
        .GATE_CYCLES (G)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .enter_req_i     (enter_req),
        .exit_req_i      (exit_req),
        .exit_slot_i     (exit_slot),
        .capacity_i      (capacity),
        .park_location_o (park_location),
        .loc_valid_o     (loc_valid),
        .grant_slot_o    (grant_slot),
        .enter_ack_o     (enter_ack),
        .enter_nack_o    (enter_nack),
        .exit_ack_o      (exit_ack),
        .exit_nack_o     (exit_nack),
        .gate_open_o     (gate_open),
        .free_count_o    (free_count),
        .full_o          (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int count_free(input logic [7:0] c);
        int n = 0;
        for (int i = 0; i < N; i++) if (!c[i]) n++;
        return n;
    endfunction

    function automatic int lowest_free(input logic [7:0] c);
        for (int i = 0; i < N; i++) if (!c[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({park_location, loc_valid, grant_slot, enter_ack, enter_nack,
                    exit_ack, exit_nack, gate_open, free_count, full});
    endfunction

    // One request presented in an IDLE cycle (cycle 0), followed through to the next IDLE.
    task automatic do_req(input logic en, input logic ex, input logic [2:0] slot);
        int         exp_slot;
        bit         grant;
        int         nfree;
        logic [7:0] exp_park;
        @(negedge clk);
        enter_req = en;
        exit_req  = ex;
        exit_slot = slot;
        capacity  = model_cap;
        nfree     = count_free(model_cap);
        if (ex) begin
            exp_slot = int'(slot);
            grant    = (exp_slot < N) && model_cap[slot];
        end else begin
            exp_slot = lowest_free(model_cap);
            grant    = (exp_slot >= 0);
        end
        exp_park = grant ? 8'(1 << exp_slot) : 8'h00;

        @(negedge clk);
        check_eq("enter_ack", 32'(enter_ack), 32'(en && !ex && grant));
        check_eq("enter_nack", 32'(enter_nack), 32'(en && !ex && !grant));
        check_eq("exit_ack", 32'(exit_ack), 32'(ex && grant));
        check_eq("exit_nack", 32'(exit_nack), 32'(ex && !grant));
        check_eq("loc_valid", 32'(loc_valid), 32'(grant));
        check_eq("park_location", 32'(park_location), 32'(exp_park));
        check_eq("grant_slot", 32'(grant_slot), grant ? 32'(exp_slot) : 32'(last_grant));
        check_eq("free_count", 32'(free_count), 32'(nfree));
        check_eq("full", 32'(full), 32'(nfree == 0));
        check_eq("gate_c1", 32'(gate_open), 32'd0);
        if (ex) exit_req = 1'b0;
        else    enter_req = 1'b0;

        if (grant) begin
            last_grant = 3'(exp_slot);
            model_cap  = model_cap ^ exp_park;
            @(posedge clk);
            #1 capacity = model_cap;
            for (int c = 2; c <= 2 + G; c++) begin
                @(negedge clk);
                check_eq($sformatf("gate_c%0d", c), 32'(gate_open), 32'(c >= 3));
                check_eq($sformatf("quiet_c%0d", c),
                         32'({loc_valid, park_location, enter_ack, enter_nack, exit_ack,
                              exit_nack}), 32'd0);
            end
            check_eq("grant_hold", 32'(grant_slot), 32'(exp_slot));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            exit_slot = 3'($urandom_range(0, 7));
            capacity  = model_cap;
            check_eq("idle_quiet", 32'({loc_valid, enter_ack, enter_nack, exit_ack, exit_nack,
                                        gate_open}), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seen;
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        enter_req  = 1'b0;
        exit_req   = 1'b0;
        exit_slot  = 3'd0;
        capacity   = 8'h00;
        model_cap  = 8'h00;
        last_grant = 3'd0;

        // Reset: two cycles low, everything zero, free_count valid one cycle after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs", all_outs(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_free_count", 32'(free_count), 32'd8);
        check_eq("rel_full", 32'(full), 32'd0);

        // Entry picks lowest free slot (3).
        model_cap = 8'b0000_0111;
        do_req(1'b1, 1'b0, 3'd6);
        idle_cycles(1);

        // Full lot refuses entry.
        model_cap = 8'hFF;
        do_req(1'b1, 1'b0, 3'd0);
        idle_cycles(1);

        // Valid exit then exit from an empty slot.
        model_cap = 8'b0010_0000;
        do_req(1'b0, 1'b1, 3'd5);
        do_req(1'b0, 1'b1, 3'd2);

        // Simultaneous: exit first, held entry then takes the freed slot 0.
        model_cap = 8'h01;
        do_req(1'b1, 1'b1, 3'd0);
        check_eq("enter_still_held", 32'(enter_req), 32'd1);
        do_req(1'b1, 1'b0, 3'd0);
        check_eq("sim_slot0", 32'(grant_slot), 32'd0);

        // Eight back-to-back entries fill slots in order, ninth refused.
        model_cap = 8'h00;
        seen      = 8'h00;
        for (int i = 0; i < N; i++) begin
            do_req(1'b1, 1'b0, 3'($urandom_range(0, 7)));
            check_eq("fill_order", 32'(grant_slot), 32'(i));
            check_eq("fill_dup", 32'(seen & (8'h01 << grant_slot)), 32'd0);
            seen = seen | (8'h01 << grant_slot);
        end
        do_req(1'b1, 1'b0, 3'd0);

        // Reset asserted while the gate is open closes it on the next edge.
        @(negedge clk);
        exit_req  = 1'b1;
        exit_slot = 3'd3;
        capacity  = model_cap;
        @(negedge clk);
        check_eq("rg_exit_ack", 32'(exit_ack), 32'd1);
        exit_req   = 1'b0;
        model_cap  = model_cap ^ 8'h08;
        @(posedge clk);
        #1 capacity = model_cap;
        @(negedge clk);
        @(negedge clk);
        check_eq("rg_gate_open", 32'(gate_open), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rg_gate_closed", 32'(gate_open), 32'd0);
        check_eq("rg_outs", all_outs(), 32'd0);
        rst_n      = 1'b1;
        last_grant = 3'd0;
        do_req(1'b1, 1'b0, 3'd0);

        // Randomized traffic against the model.
        for (int it = 0; it < 80; it++) begin
            int k;
            k = $urandom_range(0, 7);
            if (k == 0) model_cap = 8'hFF;
            else if (k < 3) model_cap = 8'($urandom);
            k = $urandom_range(0, 3);
            case (k)
                0: do_req(1'b1, 1'b0, 3'($urandom_range(0, 7)));
                1: do_req(enter_req, 1'b1, 3'($urandom_range(0, 7)));
                2: do_req(1'b1, 1'b1, 3'($urandom_range(0, 7)));
                default: begin
                    if (enter_req) do_req(1'b1, 1'b0, 3'd0);
                    else idle_cycles(2);
                end
            endcase
        end
        if (enter_req) do_req(1'b1, 1'b0, 3'd0);
        idle_cycles(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
